booth_operand_sequencer: RTL and testbench

//  Upstream feeder for the sequential Booth multiplier. Buffers signed operand

---
 rtl/booth_operand_sequencer.sv | 176 +++++++++++++++++
 tb/tb_booth_operand_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_operand_sequencer.sv
// Operand FIFO and issue FSM feeding a sequential Booth multiplier, with a
// valid/ready result register and a watchdog that abandons lost operations.
module booth_operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,   // power of 2, >= 2
  parameter int TIMEOUT = 32   // must exceed the multiplier latency
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               timeout_err,
  output logic               busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [WD_W-1:0]    watchdog;

  logic push;
  logic pop;
  logic capture;
  logic fifo_nonempty;

  // ---------------------------------------------------------------------------
  // Operand FIFO
  // ---------------------------------------------------------------------------
  // Readiness looks only at the occupancy, so a full FIFO refuses a push even
  // in a cycle where the FSM pops.
  assign in_ready      = (count < FULL_COUNT);
  assign fifo_nonempty = (count != '0);
  assign push          = in_valid && in_ready;

  // NOTE: the storage array carries no reset; only pointers and count define
  // which entries are live, so flushing them is enough and the RAM stays lean.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b};
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all state
  // updates see the pre-edge values, matching the hardware registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    mul_start   = 1'b0;
    capture     = 1'b0;
    timeout_err = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A held, unconsumed result blocks the next issue.
        if (fifo_nonempty && (!out_valid || out_ready)) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mul_start  = 1'b1;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        // A done arriving on the last allowed cycle still wins over the abort.
        if (mul_done) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end else if (watchdog == WD_LAST) begin
          timeout_err = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      watchdog <= '0;
    end else if (pop) begin
      watchdog <= '0;
    end else if (state == ST_WAIT && state_next == ST_WAIT) begin
      watchdog <= watchdog + 1'b1;
    end
  end

  // Operands stay on the multiplier inputs until the next pop replaces them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (pop) begin
      {mul_a, mul_b} <= mem[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_result <= mul_result;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign busy = (state != ST_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Self-checking bench: cycle-level behavioural model of the sequencer plus a
// stand-in multiplier, directed scenarios with literal expectations, then random traffic.
module tb_booth_operand_sequencer;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done = 1'b0;
  logic [15:0] mul_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        timeout_err;
  logic        busy;

  booth_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .timeout_err(timeout_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
  endfunction

  // Stand-in multiplier: answers a start after 'lat' cycles unless told to drop it.
  int          lat = 8;
  bit          no_resp = 1'b0;
  bit          noise = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_prod = '0;

  initial forever begin
    @(negedge clk);
    if (mul_start && !no_resp) begin
      pend      = 1'b1;
      pend_cnt  = lat - 1;
      pend_prod = model_mul(mul_a, mul_b);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pend && pend_cnt == 0) begin
      mul_done   = 1'b1;
      mul_result = pend_prod;
      pend       = 1'b0;
    end else begin
      if (pend) pend_cnt--;
      mul_done   = noise && ($urandom_range(0, 39) == 0);
      mul_result = mul_done ? 16'($urandom) : 16'h0;
    end
  end

  // Behavioural model: a queue of pending pairs and the age of the op in flight
  // (age 0 = start cycle, age k >= 1 = k-th cycle spent waiting for done).
  logic [15:0] q[$];
  bit          op_active = 1'b0;
  int          op_age = 0;
  logic        m_out_valid = 1'b0;
  logic [15:0] m_out_result = '0;
  logic [7:0]  m_a = '0;
  logic [7:0]  m_b = '0;

  task automatic model_step();
    bit accept, pop_now, done_now, finish;
    if (!reset) begin
      q.delete();
      op_active    = 1'b0;
      op_age       = 0;
      m_out_valid  = 1'b0;
      m_out_result = '0;
      m_a          = '0;
      m_b          = '0;
    end else begin
      accept   = in_valid && (q.size() < DEPTH);
      pop_now  = !op_active && (q.size() != 0) && (!m_out_valid || out_ready);
      done_now = op_active && op_age >= 1 && mul_done;
      finish   = done_now || (op_active && op_age == TIMEOUT);
      if (done_now) begin
        m_out_valid  = 1'b1;
        m_out_result = mul_result;
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 1'b0;
      end
      if (finish) op_active = 1'b0;
      else if (op_active) op_age++;
      if (pop_now) begin
        {m_a, m_b} = q.pop_front();
        op_active  = 1'b1;
        op_age     = 0;
      end
      if (accept) q.push_back({in_a, in_b});
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    check("cmp_mul_start",   32'(mul_start),   32'(op_active && op_age == 0));
    check("cmp_mul_a",       32'(mul_a),       32'(m_a));
    check("cmp_mul_b",       32'(mul_b),       32'(m_b));
    check("cmp_out_valid",   32'(out_valid),   32'(m_out_valid));
    check("cmp_out_result",  32'(out_result),  32'(m_out_result));
    check("cmp_timeout_err", 32'(timeout_err), 32'(op_active && op_age == TIMEOUT && !mul_done));
    check("cmp_busy",        32'(busy),        32'(op_active || q.size() != 0));
    check("cmp_in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
  end

  // Accepted results and abort pulses, as seen by a consumer.
  logic [15:0] got[$];
  int          n_tmo = 0;

  initial forever begin
    @(negedge clk);
    if (reset && out_valid && out_ready) got.push_back(out_result);
    if (timeout_err) n_tmo++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mul_start && k < 100);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || out_valid) && k < 500);
    check(name, 32'(!busy && !out_valid), 1);
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         k;
    int         starts;
    logic [7:0] pa[6];
    logic [7:0] pb[6];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",        32'(busy), 0);
    check("rst_out_valid",   32'(out_valid), 0);
    check("rst_mul_start",   32'(mul_start), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_out_result",  32'(out_result), 0);
    step();
    reset = 1'b1;

    // 1: single op, latency and result hold
    out_ready = 1'b0;
    lat = 8;
    step();
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'hFE;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_no_start_n1", 32'(mul_start), 0);
    step();
    @(negedge clk);
    check("t1_start_n2", 32'(mul_start), 1);
    check("t1_mul_a", 32'(mul_a), 32'h03);
    check("t1_mul_b", 32'(mul_b), 32'hFE);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t1_done_latency", k, 9);
    check("t1_result", 32'(out_result), 32'hFFFA);
    check("t1_model_result", 32'(m_out_result), 32'hFFFA);
    repeat (5) begin
      @(negedge clk);
      check("t1_hold_valid", 32'(out_valid), 1);
      check("t1_hold_result", 32'(out_result), 32'hFFFA);
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("t1_cleared", 32'(out_valid), 0);

    // 2: fill the FIFO behind a stalled op
    lat = 20;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    step();
    in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    step();
    in_valid = 1'b0;
    wait_start(k);
    check("t2_first_start", 32'(mul_start), 1);
    step();
    in_valid = 1'b1;
    for (int i = 1; i < 6; i++) begin
      in_a = pa[i];
      in_b = pb[i];
      if (i == 5) check("t2_full_after_4", 32'(in_ready), 0);
      k = 0;
      while (!in_ready && k < 100) begin
        step();
        k++;
      end
      if (i == 5) check("t2_fifth_waited", 32'(k > 0), 1);
      step();
    end
    in_valid = 1'b0;
    wait_idle("t2_drain");
    check("t2_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_order", got_at(i), 32'(model_mul(pa[i], pb[i])));

    // 3: held result blocks further issues
    lat = 3;
    out_ready = 1'b0;
    got.delete();
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = pa[i] ^ 8'h5A;
      in_b = pb[i] + 8'd1;
      step();
    end
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t3_first_result", 32'(out_valid), 1);
    starts = 0;
    repeat (12) begin
      @(negedge clk);
      if (mul_start) starts++;
    end
    check("t3_no_issue_while_held", starts, 0);
    check("t3_busy", 32'(busy), 1);
    step();
    out_ready = 1'b1;
    wait_start(k);
    check("t3_issue_after_ready", k, 2);
    wait_idle("t3_drain");
    check("t3_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t3_order", got_at(i), 32'(model_mul(pa[i] ^ 8'h5A, pb[i] + 8'd1)));

    // 4: lost done -> abort, next pair issued normally
    lat = 5;
    no_resp = 1'b1;
    got.delete();
    n_tmo = 0;
    step();
    in_valid = 1'b1; in_a = 8'd10; in_b = 8'd20;
    step();
    in_a = 8'hFB; in_b = 8'd7;
    step();
    in_valid = 1'b0;
    wait_start(k);
    check("t4_start", 32'(mul_start), 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timeout_err && k < TIMEOUT + 8);
    check("t4_timeout_cycle", k, TIMEOUT);
    check("t4_no_valid", 32'(out_valid), 0);
    step();
    no_resp = 1'b0;
    wait_start(k);
    check("t4_reissue", 32'(mul_start), 1);
    check("t4_reissue_a", 32'(mul_a), 32'hFB);
    wait_idle("t4_drain");
    check("t4_count", got.size(), 1);
    check("t4_result", got_at(0), 32'hFFDD);
    check("t4_one_abort", n_tmo, 1);

    // 5: reset in the middle of an op with three queued
    lat = 10;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 8'(i + 1);
      in_b = 8'(i + 2);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t5_busy_before", 32'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_mul_start", 32'(mul_start), 0);
    check("t5_rst_mul_a", 32'(mul_a), 0);
    check("t5_rst_out_valid", 32'(out_valid), 0);
    check("t5_rst_out_result", 32'(out_result), 0);
    check("t5_rst_timeout", 32'(timeout_err), 0);
    check("t5_rst_busy", 32'(busy), 0);
    step();
    step();
    reset = 1'b1;
    starts = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid || busy) starts++;
    end
    check("t5_late_done_ignored", starts, 0);
    got.delete();
    step();
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'hF7;
    step();
    in_valid = 1'b0;
    wait_idle("t5_fresh_drain");
    check("t5_fresh_result", got_at(0), 32'hFFC1);

    // 6: arithmetic corners
    lat = 4;
    got.delete();
    step();
    in_valid = 1'b1; in_a = 8'h80; in_b = 8'h80;
    step();
    in_b = 8'h7F;
    step();
    in_valid = 1'b0;
    wait_idle("t6_drain");
    check("t6_neg_neg", got_at(0), 32'h4000);
    check("t6_neg_pos", got_at(1), 32'hC080);

    // Random traffic with spurious dones, dropped ops and occasional resets
    noise = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      step();
      reset     = ($urandom_range(0, 499) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      lat       = $urandom_range(1, 12);
      no_resp   = ($urandom_range(0, 15) == 0);
    end
    step();
    reset = 1'b1;
    in_valid = 1'b0;
    noise = 1'b0;
    no_resp = 1'b0;
    out_ready = 1'b1;
    wait_idle("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
